balanca_preco_seq: RTL and testbench
====================================

Name: balanca_preco_seq

Overview:
- Sequential, parametrised successor of the combinational scale-pricing block.
- Takes a gross weight in grams and a price per kg in cents, subtracts a latched tare, and computes a rounded item price.
- Splits weight, price per kg and item price into integer and decimal parts using one shared iterative restoring divider.
- Keeps a running basket total, and sits between the load-cell front end and the display driver.

Parameters:
- PESO_W, 14, width of weightInGrams (grams).
- PRECO_W, 14, width of centimos (price per kg in cents).
- ACC_W, 24, width of the basket total accumulator (cents).
- CNT_W, 8, width of the item counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- acumular  in  1  sampled with start; when 1, the result is added to the basket total.
- tara_load  in  1  latches weightInGrams as tare; honoured only in IDLE.
- limpar_total  in  1  clears the basket total and item counter.
- weightInGrams  in  PESO_W  gross weight in grams.
- centimos  in  PRECO_W  price per kg in cents.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- tara_neg  out  1  net weight saturated to 0 (tare > gross).
- Peso_Final_unidades  out  PESO_W  net kg.
- Peso_Final_decimal  out  10  net grams remainder, 0..999.
- Preco_Por_Kg_Parte_Inteira  out  PRECO_W  centimos/100.
- Preco_Por_Kg_Parte_Decimal  out  7  centimos%100.
- Preco_Parte_Inteira  out  PC_W  item price, euros.
- Preco_Parte_Decimal  out  7  item price, cents 0..99.
- total_centimos  out  ACC_W  basket total in cents.
- n_itens  out  CNT_W  items accumulated.

Behaviour:
- Derived width: PC_W = PESO_W+PRECO_W-9 (19 by default).
- Reset (async, rst_n=0): every output is 0, tare register is 0, FSM goes to IDLE. Reset mid-operation aborts the computation with no done pulse.
- FSM states: IDLE, MUL, DIV_PRECO, SPLIT_PRECO, SPLIT_PESO, SPLIT_PPK, DONE.
- IDLE -> MUL on start:
  - Latch net = max(weightInGrams - tare, 0); set tara_neg when tare > gross.
  - Latch centimos and acumular.
- MUL (1 cycle): prod = net*centimos + 500, width PESO_W+PRECO_W+1, no overflow possible.
- DIV_PRECO (PESO_W+PRECO_W cycles): pc = prod/1000, which is round-half-up of the true price.
- SPLIT_PRECO (PC_W cycles): pc/100 and pc%100.
- SPLIT_PESO (PESO_W cycles): net/1000 and net%1000.
- SPLIT_PPK (PRECO_W cycles): centimos/100 and centimos%100.
- Each divider step produces one quotient bit per cycle. Sequencing is fixed and is not data-dependent.
- DONE (1 cycle):
  - Result registers update together and done=1.
  - If the latched acumular=1: total_centimos += pc, saturating at 2^ACC_W-1; n_itens += 1, saturating.
  - Next state IDLE.
- Latency: done is high exactly 2+(PESO_W+PRECO_W)+PC_W+PESO_W+PRECO_W cycles after the start-sampling edge (77 by default).
- busy=1 in every non-IDLE state.
- Result outputs hold their values until the next done or reset. Intermediate values never appear on the outputs.
- start while busy: ignored, not queued.
- tara_load while busy: ignored. tara_load and start in the same IDLE cycle: tare is loaded first, and that cycle's net uses the new tare (net=0).
- limpar_total: takes effect in any state the next cycle. If it coincides with the DONE accumulate, clear wins (total=0, n_itens=0).
- Inputs weightInGrams and centimos may change freely after the start cycle.

Test Plan:
1. Nominal: tare 0, weightInGrams=1500, centimos=470, start.
   -> done after 77 cycles.
   -> Peso 1/500, PPK 4/70, Preco 7/05, tara_neg=0.
2. Rounding:
   - weight 1, centimos 500 -> Preco 0/01.
   - weight 1, centimos 499 -> Preco 0/00.
   - weight 3, centimos 16383 -> 49.149 rounds to 0/49.
3. Tare:
   - weight 200 with tara_load; then weight 1200, centimos 1000, start -> Peso 1/000, Preco 10/00.
   - Then weight 100 -> Peso 0/000, Preco 0/00, tara_neg=1.
4. Maximum: weight 16383, centimos 16383.
   -> Peso 16/383, PPK 163/83, Preco 2684/03.
5. Basket:
   - Items 705 and 1000 cents with acumular=1 -> total_centimos=1705, n_itens=2.
   - A third start with acumular=0 leaves the total unchanged.
   - limpar_total asserted in the DONE cycle -> 0/0.
   - start re-pulsed at cycle 10 of busy is ignored (single done).
6. Reset: rst_n low at cycle 30 of an operation.
   -> Outputs, busy and tare are 0 immediately.
   -> No done pulse.
   -> A new start after release completes normally in 77 cycles.

Source files
------------

// File: rtl/balanca_preco_seq.sv
// balanca_preco_seq: sequential scale-pricing block.
// A latched tare is subtracted from the gross weight, and the net weight is
// multiplied by the price per kg. The rounded item price and the display
// splits are then produced by one shared restoring divider that yields one
// quotient bit per cycle. A saturating basket total and an item counter are
// maintained alongside.
module balanca_preco_seq #(
  parameter int PESO_W  = 14,
  parameter int PRECO_W = 14,
  parameter int ACC_W   = 24,
  parameter int CNT_W   = 8,
  localparam int PC_W   = PESO_W + PRECO_W - 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               acumular,
  input  logic               tara_load,
  input  logic               limpar_total,
  input  logic [PESO_W-1:0]  weightInGrams,
  input  logic [PRECO_W-1:0] centimos,
  output logic               busy,
  output logic               done,
  output logic               tara_neg,
  output logic [PESO_W-1:0]  Peso_Final_unidades,
  output logic [9:0]         Peso_Final_decimal,
  output logic [PRECO_W-1:0] Preco_Por_Kg_Parte_Inteira,
  output logic [6:0]         Preco_Por_Kg_Parte_Decimal,
  output logic [PC_W-1:0]    Preco_Parte_Inteira,
  output logic [6:0]         Preco_Parte_Decimal,
  output logic [ACC_W-1:0]   total_centimos,
  output logic [CNT_W-1:0]   n_itens
);

  // The divider's dividend register is as wide as the largest dividend.
  // The product plus the rounding offset always fits in DW bits for these
  // widths, so the top bit of the full-width product is never set.
  localparam int DW = PESO_W + PRECO_W;
  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MUL         = 3'd1,
    DIV_PRECO   = 3'd2,
    SPLIT_PRECO = 3'd3,
    SPLIT_PESO  = 3'd4,
    SPLIT_PPK   = 3'd5,
    DONE        = 3'd6
  } state_t;

  state_t             state_r;

  // Operands latched when a request is accepted.
  logic [PESO_W-1:0]  tara_r;
  logic [PESO_W-1:0]  net_r;
  logic [PRECO_W-1:0] ppk_r;
  logic               acc_r;
  logic               neg_r;
  logic [PC_W-1:0]    pc_r;

  // Shared divider state.
  logic [DW-1:0]      dvd_r;
  logic [9:0]         rem_r;
  logic [9:0]         div_r;
  logic [CW-1:0]      cnt_r;

  // Staged results that are copied to the outputs together in DONE.
  logic [PC_W-1:0]    preco_int_r;
  logic [6:0]         preco_dec_r;
  logic [PESO_W-1:0]  peso_int_r;
  logic [9:0]         peso_dec_r;
  logic [PRECO_W-1:0] ppk_int_r;
  logic [6:0]         ppk_dec_r;

  // Combinational helpers.
  logic [PESO_W-1:0]  tara_eff_s;
  logic [PESO_W-1:0]  net_s;
  logic               neg_s;
  logic [DW-1:0]      prod_s;
  logic [10:0]        r_s;
  logic               q_s;
  logic [9:0]         rem_next_s;
  logic [DW-1:0]      dvd_next_s;
  logic               last_s;
  logic [ACC_W:0]     sum_s;

  // Net weight: a tare loaded in the same cycle as start is applied immediately.
  always_comb begin
    tara_eff_s = tara_r;
    net_s      = {PESO_W{1'b0}};
    neg_s      = 1'b0;
    if (tara_load) begin
      tara_eff_s = weightInGrams;
    end else begin
      tara_eff_s = tara_r;
    end
    if (weightInGrams >= tara_eff_s) begin
      net_s = weightInGrams - tara_eff_s;
      neg_s = 1'b0;
    end else begin
      net_s = {PESO_W{1'b0}};
      neg_s = 1'b1;
    end
  end

  // Product with a +500 offset, so the later divide by 1000 rounds half up.
  always_comb begin
    prod_s = {{PRECO_W{1'b0}}, net_r} * {{PESO_W{1'b0}}, ppk_r}
           + {{(DW-10){1'b0}}, 10'd500};
  end

  // One restoring-division step: shift in the dividend MSB, then subtract if possible.
  always_comb begin
    r_s        = {rem_r, dvd_r[DW-1]};
    q_s        = 1'b0;
    rem_next_s = r_s[9:0];
    if (r_s >= {1'b0, div_r}) begin
      q_s        = 1'b1;
      rem_next_s = r_s[9:0] - div_r;
    end else begin
      q_s        = 1'b0;
      rem_next_s = r_s[9:0];
    end
    dvd_next_s = {dvd_r[DW-2:0], q_s};
    last_s     = (cnt_r == {CW{1'b0}});
  end

  // Candidate basket total, one bit wider so that saturation can be detected.
  always_comb begin
    sum_s = {1'b0, total_centimos} + {{(ACC_W+1-PC_W){1'b0}}, pc_r};
  end

  // Main sequencer: operand capture, divider phases, and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                    <= IDLE;
      tara_r                     <= {PESO_W{1'b0}};
      net_r                      <= {PESO_W{1'b0}};
      ppk_r                      <= {PRECO_W{1'b0}};
      acc_r                      <= 1'b0;
      neg_r                      <= 1'b0;
      pc_r                       <= {PC_W{1'b0}};
      dvd_r                      <= {DW{1'b0}};
      rem_r                      <= 10'd0;
      div_r                      <= 10'd0;
      cnt_r                      <= {CW{1'b0}};
      preco_int_r                <= {PC_W{1'b0}};
      preco_dec_r                <= 7'd0;
      peso_int_r                 <= {PESO_W{1'b0}};
      peso_dec_r                 <= 10'd0;
      ppk_int_r                  <= {PRECO_W{1'b0}};
      ppk_dec_r                  <= 7'd0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      tara_neg                   <= 1'b0;
      Peso_Final_unidades        <= {PESO_W{1'b0}};
      Peso_Final_decimal         <= 10'd0;
      Preco_Por_Kg_Parte_Inteira <= {PRECO_W{1'b0}};
      Preco_Por_Kg_Parte_Decimal <= 7'd0;
      Preco_Parte_Inteira        <= {PC_W{1'b0}};
      Preco_Parte_Decimal        <= 7'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tara_load) begin
            tara_r <= weightInGrams;
          end else begin
            tara_r <= tara_r;
          end
          if (start) begin
            net_r   <= net_s;
            neg_r   <= neg_s;
            ppk_r   <= centimos;
            acc_r   <= acumular;
            busy    <= 1'b1;
            state_r <= MUL;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        MUL: begin
          dvd_r   <= prod_s;
          rem_r   <= 10'd0;
          div_r   <= 10'd1000;
          cnt_r   <= CW'(DW - 1);
          state_r <= DIV_PRECO;
        end
        DIV_PRECO: begin
          if (last_s) begin
            pc_r    <= dvd_next_s[PC_W-1:0];
            dvd_r   <= {dvd_next_s[PC_W-1:0], {(DW-PC_W){1'b0}}};
            rem_r   <= 10'd0;
            div_r   <= 10'd100;
            cnt_r   <= CW'(PC_W - 1);
            state_r <= SPLIT_PRECO;
          end else begin
            dvd_r   <= dvd_next_s;
            rem_r   <= rem_next_s;
            cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        SPLIT_PRECO: begin
          if (last_s) begin
            preco_int_r <= dvd_next_s[PC_W-1:0];
            preco_dec_r <= rem_next_s[6:0];
            dvd_r       <= {net_r, {(DW-PESO_W){1'b0}}};
            rem_r       <= 10'd0;
            div_r       <= 10'd1000;
            cnt_r       <= CW'(PESO_W - 1);
            state_r     <= SPLIT_PESO;
          end else begin
            dvd_r       <= dvd_next_s;
            rem_r       <= rem_next_s;
            cnt_r       <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        SPLIT_PESO: begin
          if (last_s) begin
            peso_int_r <= dvd_next_s[PESO_W-1:0];
            peso_dec_r <= rem_next_s;
            dvd_r      <= {ppk_r, {(DW-PRECO_W){1'b0}}};
            rem_r      <= 10'd0;
            div_r      <= 10'd100;
            cnt_r      <= CW'(PRECO_W - 1);
            state_r    <= SPLIT_PPK;
          end else begin
            dvd_r      <= dvd_next_s;
            rem_r      <= rem_next_s;
            cnt_r      <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        SPLIT_PPK: begin
          if (last_s) begin
            ppk_int_r <= dvd_next_s[PRECO_W-1:0];
            ppk_dec_r <= rem_next_s[6:0];
            state_r   <= DONE;
          end else begin
            dvd_r     <= dvd_next_s;
            rem_r     <= rem_next_s;
            cnt_r     <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          Peso_Final_unidades        <= peso_int_r;
          Peso_Final_decimal         <= peso_dec_r;
          Preco_Por_Kg_Parte_Inteira <= ppk_int_r;
          Preco_Por_Kg_Parte_Decimal <= ppk_dec_r;
          Preco_Parte_Inteira        <= preco_int_r;
          Preco_Parte_Decimal        <= preco_dec_r;
          tara_neg                   <= neg_r;
          done                       <= 1'b1;
          busy                       <= 1'b0;
          state_r                    <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Basket total and item counter; a clear request overrides a same-cycle accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_centimos <= {ACC_W{1'b0}};
      n_itens        <= {CNT_W{1'b0}};
    end else if (limpar_total) begin
      total_centimos <= {ACC_W{1'b0}};
      n_itens        <= {CNT_W{1'b0}};
    end else if ((state_r == DONE) && acc_r) begin
      if (sum_s[ACC_W]) begin
        total_centimos <= {ACC_W{1'b1}};
      end else begin
        total_centimos <= sum_s[ACC_W-1:0];
      end
      if (n_itens != {CNT_W{1'b1}}) begin
        n_itens <= n_itens + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        n_itens <= n_itens;
      end
    end else begin
      total_centimos <= total_centimos;
      n_itens        <= n_itens;
    end
  end

endmodule

// File: tb/tb_balanca_preco_seq.sv
// Directed bench for balanca_preco_seq with hand-computed expected values.
module tb_balanca_preco_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        acumular;
  logic        tara_load;
  logic        limpar_total;
  logic [13:0] weightInGrams;
  logic [13:0] centimos;
  logic        busy;
  logic        done;
  logic        tara_neg;
  logic [13:0] Peso_Final_unidades;
  logic [9:0]  Peso_Final_decimal;
  logic [13:0] Preco_Por_Kg_Parte_Inteira;
  logic [6:0]  Preco_Por_Kg_Parte_Decimal;
  logic [18:0] Preco_Parte_Inteira;
  logic [6:0]  Preco_Parte_Decimal;
  logic [23:0] total_centimos;
  logic [7:0]  n_itens;

  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   done_cnt;
  logic busy_k1;

  balanca_preco_seq dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .start                      (start),
    .acumular                   (acumular),
    .tara_load                  (tara_load),
    .limpar_total               (limpar_total),
    .weightInGrams              (weightInGrams),
    .centimos                   (centimos),
    .busy                       (busy),
    .done                       (done),
    .tara_neg                   (tara_neg),
    .Peso_Final_unidades        (Peso_Final_unidades),
    .Peso_Final_decimal         (Peso_Final_decimal),
    .Preco_Por_Kg_Parte_Inteira (Preco_Por_Kg_Parte_Inteira),
    .Preco_Por_Kg_Parte_Decimal (Preco_Por_Kg_Parte_Decimal),
    .Preco_Parte_Inteira        (Preco_Parte_Inteira),
    .Preco_Parte_Decimal        (Preco_Parte_Decimal),
    .total_centimos             (total_centimos),
    .n_itens                    (n_itens)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int pi, input int pd, input int ki,
                         input int kd, input int ci, input int cd, input int ng);
    chk({tag, "_peso_int"}, 32'(Peso_Final_unidades), pi);
    chk({tag, "_peso_dec"}, 32'(Peso_Final_decimal), pd);
    chk({tag, "_ppk_int"}, 32'(Preco_Por_Kg_Parte_Inteira), ki);
    chk({tag, "_ppk_dec"}, 32'(Preco_Por_Kg_Parte_Decimal), kd);
    chk({tag, "_preco_int"}, 32'(Preco_Parte_Inteira), ci);
    chk({tag, "_preco_dec"}, 32'(Preco_Parte_Decimal), cd);
    chk({tag, "_tara_neg"}, 32'(tara_neg), ng);
  endtask

  // Pulses start, scrambles the inputs afterwards, and waits (bounded) for done.
  task automatic run_op(input logic [13:0] w, input logic [13:0] c, input logic a,
                        input logic tl, input int repulse, input logic clr,
                        output int lat_o);
    @(negedge clk);
    weightInGrams = w;
    centimos      = c;
    acumular      = a;
    tara_load     = tl;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    acumular      = 1'b0;
    tara_load     = 1'b0;
    weightInGrams = 14'h2AAA;
    centimos      = 14'h1555;
    lat_o = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) busy_k1 = busy;
      if (done) begin
        lat_o = k;
        break;
      end
      if (k == repulse) start = 1'b1;
      else start = 1'b0;
      if (clr && (k == 76)) limpar_total = 1'b1;
      else limpar_total = 1'b0;
    end
    start        = 1'b0;
    limpar_total = 1'b0;
  endtask

  task automatic load_tare(input logic [13:0] w);
    @(negedge clk);
    weightInGrams = w;
    tara_load     = 1'b1;
    @(posedge clk);
    #1;
    tara_load     = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b1;
    start         = 1'b0;
    acumular      = 1'b0;
    tara_load     = 1'b0;
    limpar_total  = 1'b0;
    weightInGrams = 14'd0;
    centimos      = 14'd0;
    #2;
    rst_n = 1'b0;
    #20;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk_res("rst", 0, 0, 0, 0, 0, 0, 0);
    chk("rst_total", 32'(total_centimos), 0);
    chk("rst_nitens", 32'(n_itens), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Nominal: 1500 g at 470 c/kg -> 705000+500 -> 705 cents.
    run_op(14'd1500, 14'd470, 1'b0, 1'b0, 0, 1'b0, lat);
    chk("t1_latency", 32'(lat), 77);
    chk("t1_busy_during", 32'(busy_k1), 1);
    chk("t1_busy_at_done", 32'(busy), 0);
    chk_res("t1", 1, 500, 4, 70, 7, 5, 0);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_hold_preco", 32'(Preco_Parte_Decimal), 5);

    // 2. Rounding boundaries.
    run_op(14'd1, 14'd500, 1'b0, 1'b0, 0, 1'b0, lat);
    chk("t2a_latency", 32'(lat), 77);
    chk_res("t2a", 0, 1, 5, 0, 0, 1, 0);
    run_op(14'd1, 14'd499, 1'b0, 1'b0, 0, 1'b0, lat);
    chk_res("t2b", 0, 1, 4, 99, 0, 0, 0);
    run_op(14'd3, 14'd16383, 1'b0, 1'b0, 0, 1'b0, lat);
    chk_res("t2c", 0, 3, 163, 83, 0, 49, 0);

    // Tare load and start together: the new tare applies, so net is 0 without negation.
    run_op(14'd500, 14'd1000, 1'b0, 1'b1, 0, 1'b0, lat);
    chk_res("t3s", 0, 0, 10, 0, 0, 0, 0);

    // 3. Tare 200: 1200 g at 1000 c/kg -> 1000 g -> 1000 cents.
    load_tare(14'd200);
    run_op(14'd1200, 14'd1000, 1'b0, 1'b0, 0, 1'b0, lat);
    chk_res("t3a", 1, 0, 10, 0, 10, 0, 0);
    run_op(14'd100, 14'd1000, 1'b0, 1'b0, 0, 1'b0, lat);
    chk_res("t3b", 0, 0, 10, 0, 0, 0, 1);
    load_tare(14'd0);

    // 4. Maximum: 16383*16383+500 = 268403189 -> 268403 cents.
    run_op(14'd16383, 14'd16383, 1'b0, 1'b0, 0, 1'b0, lat);
    chk("t4_latency", 32'(lat), 77);
    chk_res("t4", 16, 383, 163, 83, 2684, 3, 0);

    // 5. Basket accumulation.
    run_op(14'd1500, 14'd470, 1'b1, 1'b0, 0, 1'b0, lat);
    chk("t5a_total", 32'(total_centimos), 705);
    chk("t5a_nitens", 32'(n_itens), 1);
    run_op(14'd1000, 14'd1000, 1'b1, 1'b0, 10, 1'b0, lat);
    chk("t5b_latency", 32'(lat), 77);
    chk("t5b_total", 32'(total_centimos), 1705);
    chk("t5b_nitens", 32'(n_itens), 2);
    done_cnt = 0;
    for (int k = 0; k < 90; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("t5b_single_done", 32'(done_cnt), 0);
    chk("t5b_idle_busy", 32'(busy), 0);
    run_op(14'd1, 14'd500, 1'b0, 1'b0, 0, 1'b0, lat);
    chk("t5c_total", 32'(total_centimos), 1705);
    chk("t5c_nitens", 32'(n_itens), 2);
    run_op(14'd1500, 14'd470, 1'b1, 1'b0, 0, 1'b1, lat);
    chk("t5d_latency", 32'(lat), 77);
    chk("t5d_total", 32'(total_centimos), 0);
    chk("t5d_nitens", 32'(n_itens), 0);

    // 6. Reset in mid-operation, with a non-zero tare loaded beforehand.
    load_tare(14'd300);
    @(negedge clk);
    weightInGrams = 14'd1500;
    centimos      = 14'd470;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_peso_int", 32'(Peso_Final_unidades), 0);
    chk("t6_preco_int", 32'(Preco_Parte_Inteira), 0);
    chk("t6_ppk_dec", 32'(Preco_Por_Kg_Parte_Decimal), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 90; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("t6_no_done", 32'(done_cnt), 0);
    run_op(14'd1500, 14'd470, 1'b0, 1'b0, 0, 1'b0, lat);
    chk("t6_latency", 32'(lat), 77);
    chk_res("t6", 1, 500, 4, 70, 7, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
